// File: rtl/riscv_loader_pkg.sv
`default_nettype none
// ============================================================================
// riscv_loader_pkg : shared types and sizes for the IMEM program loader
// Rev 1.0
// ============================================================================
package riscv_loader_pkg;

  localparam int LEN_WIDTH      = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } loader_state_e;

endpackage : riscv_loader_pkg
`default_nettype wire

// File: rtl/loader_word_assembler.sv
`default_nettype none
// ============================================================================
// loader_word_assembler : little-endian byte-to-word packer with XOR checksum
// Rev 1.0
// ============================================================================
module loader_word_assembler
  import riscv_loader_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            byte_valid_i,
  input  logic [7:0]      byte_i,
  output logic [XLEN-1:0] word_next_o,
  output logic            word_ready_o,
  output logic [7:0]      checksum_o
);

  // Only the first three bytes need storage; the fourth arrives with word_ready.
  logic [XLEN-9:0] shift_q, shift_d;
  logic [1:0]      count_q, count_d;
  logic [7:0]      csum_q,  csum_d;

  always_comb begin
    word_next_o  = {byte_i, shift_q};
    word_ready_o = byte_valid_i && (count_q == 2'(BYTES_PER_WORD - 1));
    shift_d      = shift_q;
    count_d      = count_q;
    csum_d       = csum_q;
    if (clear_i) begin
      shift_d = '0;
      count_d = '0;
      csum_d  = '0;
    end else if (byte_valid_i) begin
      shift_d = word_next_o[XLEN-1:8];
      count_d = count_q + 2'd1;
      csum_d  = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
      csum_q  <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      csum_q  <= csum_d;
    end
  end

  assign checksum_o = csum_q;

endmodule : loader_word_assembler
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// imem_program_loader : streams a length-prefixed, checksummed image into IMEM
// Rev 1.0
// ============================================================================
module imem_program_loader
  import riscv_loader_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          MEM_DEPTH    = 1024,
  parameter int          ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [XLEN-1:0]       imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_written
);

  localparam logic [ADDR_WIDTH-1:0] BASE    = RESET_VECTOR[ADDR_WIDTH+1:2];
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [LEN_WIDTH:0]    MAX_LEN = (LEN_WIDTH + 1)'(MEM_DEPTH);

  loader_state_e          state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [15:0]            ww_q, ww_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic                   hold_q, hold_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic                   w_accept;
  logic                   w_restart;
  logic                   w_data_byte;
  logic [LEN_WIDTH-1:0]   w_len_new;
  logic [ADDR_WIDTH:0]    w_addr_sum;
  logic [XLEN-1:0]        w_word_next;
  logic                   w_word_ready;
  logic [7:0]             w_checksum;

  assign in_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CHECK);
  assign w_accept    = in_valid && in_ready;
  assign w_data_byte = w_accept && (state_q == DATA);
  assign w_restart   = start && ((state_q == IDLE) || (state_q == DONE) ||
                                 (state_q == ERROR));
  assign w_len_new   = {in_data, len_q[7:0]};
  assign w_addr_sum  = {1'b0, BASE} + {1'b0, ww_q[ADDR_WIDTH-1:0]};

  loader_word_assembler #(
    .XLEN (XLEN)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_restart),
    .byte_valid_i (w_data_byte),
    .byte_i       (in_data),
    .word_next_o  (w_word_next),
    .word_ready_o (w_word_ready),
    .checksum_o   (w_checksum)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ww_d    = ww_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_LO;
          len_d   = '0;
          ww_d    = '0;
        end
      end
      LEN_LO: begin
        if (w_accept) begin
          len_d[7:0] = in_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (w_accept) begin
          len_d = w_len_new;
          if ({1'b0, w_len_new} > MAX_LEN) begin
            state_d = ERROR;
          end else if (w_len_new == '0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // Outputs are registered, so the write is staged here and shows during WRITE.
        if (w_word_ready) begin
          state_d = WRITE;
          we_d    = 1'b1;
          wdata_d = w_word_next;
          addr_d  = (w_addr_sum >= DEPTH_W) ? ADDR_WIDTH'(w_addr_sum - DEPTH_W)
                                            : w_addr_sum[ADDR_WIDTH-1:0];
        end
      end
      WRITE: begin
        ww_d    = ww_q + 16'd1;
        state_d = ((ww_q + 16'd1) == len_q) ? CHECK : DATA;
      end
      CHECK: begin
        if (w_accept) begin
          state_d = (in_data == w_checksum) ? DONE : ERROR;
        end
      end
      default: state_d = IDLE;
    endcase

    hold_d  = (state_d != DONE);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      ww_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ww_q    <= ww_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign core_hold     = hold_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;

endmodule : imem_program_loader
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_program_loader : directed self-checking bench for imem_program_loader
// Rev 1.0
// ============================================================================
module tb_imem_program_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;
  logic [15:0]   words_written;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            we_ready_bad = 0;
  logic [31:0]   exp_word [3];

  imem_program_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .core_hold     (core_hold),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      if (in_ready !== 1'b0) we_ready_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    we_ready_bad = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
    int n;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = poke_start && (g == 0);
      @(negedge clk);
    end
    start    = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL byte_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] cks, input bit bursty);
    logic [7:0] q[$];
    logic [31:0] w;
    q.push_back(8'h03);
    q.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      w = exp_word[i];
      for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
    end
    q.push_back(cks);
    foreach (q[i]) begin
      send_byte(q[i], bursty ? ((i * 3 + 1) % 4) : 0, bursty && ((i % 5) == 2));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", imem_we); end
    n_cmp++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_cmp++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
    n_cmp++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b want 1", core_hold); end
    n_cmp++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_flags: done=%b error=%b want 0/0", done, error); end
    n_cmp++; if (words_written !== 16'd0) begin n_fail++; $display("FAIL reset_ww: got %0d want 0", words_written); end
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || core_hold !== 1'b1) begin n_fail++; $display("FAIL idle_ignores_valid: in_ready=%b hold=%b want 0/1", in_ready, core_hold); end
  endtask

  task automatic test_load_ok();
    clear_log();
    pulse_start();
    send_image(8'hEC, 1'b0);
    n_cmp++; if (wr_addr.size() != 3) begin n_fail++; $display("FAIL ok_write_count: got %0d want 3", wr_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wr_addr.size() <= i || wr_addr[i] !== AW'(i) || wr_data[i] !== exp_word[i]) begin
        n_fail++;
        $display("FAIL ok_write%0d: addr=%h data=%h want addr=%h data=%h", i,
                 (wr_addr.size() > i) ? wr_addr[i] : 'x, (wr_data.size() > i) ? wr_data[i] : 'x,
                 AW'(i), exp_word[i]);
      end
    end
    n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL ok_flags: done=%b error=%b want 1/0", done, error); end
    n_cmp++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL ok_hold: got %b want 0", core_hold); end
    n_cmp++; if (words_written !== 16'd3) begin n_fail++; $display("FAIL ok_ww: got %0d want 3", words_written); end
    n_cmp++; if (we_ready_bad != 0) begin n_fail++; $display("FAIL ok_ready_in_write: %0d cycles had in_ready=1 want 0", we_ready_bad); end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    pulse_start();
    n_cmp++; if (done !== 1'b0 || core_hold !== 1'b1 || words_written !== 16'd0) begin
      n_fail++; $display("FAIL restart_from_done: done=%b hold=%b ww=%0d want 0/1/0", done, core_hold, words_written);
    end
    send_image(8'h00, 1'b0);
    n_cmp++; if (wr_addr.size() != 3) begin n_fail++; $display("FAIL badck_write_count: got %0d want 3", wr_addr.size()); end
    n_cmp++; if (error !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL badck_flags: error=%b done=%b want 1/0", error, done); end
    n_cmp++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL badck_hold: got %b want 1", core_hold); end
  endtask

  task automatic test_len_too_big();
    clear_log();
    pulse_start();
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL restart_from_error: error=%b want 0", error); end
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    n_cmp++; if (error !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL biglen_flags: error=%b done=%b want 1/0", error, done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL biglen_ready: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (wr_addr.size() != 0 || words_written !== 16'd0) begin
      n_fail++; $display("FAIL biglen_no_write: writes=%0d ww=%0d want 0/0", wr_addr.size(), words_written);
    end
    n_cmp++; if (error !== 1'b1 || core_hold !== 1'b1) begin n_fail++; $display("FAIL biglen_sticky: error=%b hold=%b want 1/1", error, core_hold); end
  endtask

  task automatic test_len_max_ok();
    // 0x0400 equals the depth and must not be treated as too long.
    clear_log();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    n_cmp++; if (error !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL len1024_accepted: error=%b in_ready=%b want 0/1", error, in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_len_zero();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    n_cmp++; if (done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL zero_flags: done=%b hold=%b error=%b want 1/0/0", done, core_hold, error);
    end
    n_cmp++; if (wr_addr.size() != 0 || words_written !== 16'd0) begin
      n_fail++; $display("FAIL zero_no_write: writes=%0d ww=%0d want 0/0", wr_addr.size(), words_written);
    end
  endtask

  task automatic test_bursty();
    clear_log();
    pulse_start();
    send_image(8'hEC, 1'b1);
    n_cmp++; if (wr_addr.size() != 3) begin n_fail++; $display("FAIL burst_write_count: got %0d want 3", wr_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wr_addr.size() <= i || wr_addr[i] !== AW'(i) || wr_data[i] !== exp_word[i]) begin
        n_fail++;
        $display("FAIL burst_write%0d: addr=%h data=%h want addr=%h data=%h", i,
                 (wr_addr.size() > i) ? wr_addr[i] : 'x, (wr_data.size() > i) ? wr_data[i] : 'x,
                 AW'(i), exp_word[i]);
      end
    end
    n_cmp++; if (done !== 1'b1 || words_written !== 16'd3) begin n_fail++; $display("FAIL burst_done: done=%b ww=%0d want 1/3", done, words_written); end
    n_cmp++; if (we_ready_bad != 0) begin n_fail++; $display("FAIL burst_ready_in_write: %0d cycles had in_ready=1 want 0", we_ready_bad); end
  endtask

  task automatic test_rst_midload();
    logic [31:0] w;
    clear_log();
    pulse_start();
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      w = exp_word[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 0, 1'b0);
    end
    @(negedge clk);
    n_cmp++; if (words_written !== 16'd2) begin n_fail++; $display("FAIL mid_ww_before_rst: got %0d want 2", words_written); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL mid_write_count: got %0d want 2", wr_addr.size()); end
    n_cmp++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_flags: hold=%b done=%b error=%b want 1/0/0", core_hold, done, error);
    end
    n_cmp++; if (words_written !== 16'd0 || in_ready !== 1'b0 || imem_we !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_state: ww=%0d in_ready=%b we=%b want 0/0/0", words_written, in_ready, imem_we);
    end
    n_cmp++; if (imem_addr !== '0 || imem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL mid_async_bus: addr=%h wdata=%h want 0/0", imem_addr, imem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    pulse_start();
    send_image(8'hEC, 1'b0);
    n_cmp++; if (done !== 1'b1 || words_written !== 16'd3 || wr_addr.size() != 3) begin
      n_fail++; $display("FAIL post_rst_load: done=%b ww=%0d writes=%0d want 1/3/3", done, words_written, wr_addr.size());
    end
    n_cmp++; if (wr_data.size() < 3 || wr_data[2] !== exp_word[2] || wr_addr[2] !== AW'(2)) begin
      n_fail++; $display("FAIL post_rst_last_word: data=%h addr=%h want %h/2",
                         (wr_data.size() > 2) ? wr_data[2] : 'x, (wr_addr.size() > 2) ? wr_addr[2] : 'x, exp_word[2]);
    end
  endtask

  initial begin
    exp_word[0] = 32'h0050_0093;
    exp_word[1] = 32'h00A0_0113;
    exp_word[2] = 32'hFFF0_0193;
    test_reset();
    test_load_ok();
    test_bad_checksum();
    test_len_too_big();
    test_len_max_ok();
    test_len_zero();
    test_bursty();
    test_rst_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_imem_program_loader
`default_nettype wire

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction-memory interface. The pipeline fetch stage reads instruction memory; this block fills it before the core runs.
- Receives a byte stream over a valid/ready handshake: a 16-bit word count, then little-endian instruction words, then an XOR checksum.
- Writes each assembled word into instruction memory starting at RESET_VECTOR, holding the core in reset until the image is loaded and verified.
- Sits beside riscv_pipeline_top; drives the IMEM write port and the core's reset.

Parameters:
- XLEN, 32, instruction/data word width (fixed at 32 for this block).
- MEM_DEPTH, 1024, IMEM depth in words.
- ADDR_WIDTH, $clog2(MEM_DEPTH), IMEM word-address width.
- RESET_VECTOR, 32'h00000000, byte address of the first word written.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  IMEM write enable (one-cycle pulse per word).
- imem_addr  out  ADDR_WIDTH  IMEM word address.
- imem_wdata  out  XLEN  IMEM write data.
- core_hold  out  1  active-high reset to the core.
- done  out  1  image loaded and checksum OK.
- error  out  1  length or checksum failure.
- words_written  out  16  count of words written in the current load.

Behaviour:
- Reset (async, while rst=1): state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, error=0, words_written=0, internal checksum/byte counters=0.
- A byte transfers on a rising edge with in_valid&&in_ready. in_ready is combinational from state only: 1 in LEN_LO, LEN_HI, DATA, CHECK; 0 otherwise.
- States:
  - IDLE: on start -> LEN_LO; core_hold=1, done=0, error=0, words_written=0, checksum=0, base address loaded.
  - LEN_LO: accept byte -> len[7:0]; -> LEN_HI.
  - LEN_HI: accept byte -> len[15:8]. If len>MEM_DEPTH -> ERROR; if len==0 -> CHECK; else -> DATA.
  - DATA: accept bytes LE into a shift register (byte0 -> bits 7:0); XOR each byte into checksum. On the 4th byte -> WRITE.
  - WRITE (one cycle, in_ready=0): imem_we=1, imem_wdata=assembled word, imem_addr=base+words_written (mod MEM_DEPTH); words_written increments at cycle end. If words_written+1==len -> CHECK, else -> DATA.
  - CHECK: accept one byte; equal to checksum -> DONE, else -> ERROR.
  - DONE: core_hold=0, done=1; start -> IDLE-equivalent restart (core_hold=1 in the same edge, done cleared).
  - ERROR: core_hold=1, error=1; start restarts as from DONE.
- base = RESET_VECTOR[ADDR_WIDTH+1:2]; address wraps modulo MEM_DEPTH.
- The checksum covers payload bytes only (length bytes excluded).
- start is ignored in LEN_LO..CHECK (no abort). in_valid outside receive states is ignored; no byte is consumed.
- All outputs are registered except in_ready. Latency from the 4th byte's accept edge to imem_we high: 1 cycle.
- rst mid-load: immediate return to reset values. IMEM contents already written are not erased.

Decomposition:
- Shared package riscv_loader_pkg: state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR), LEN_WIDTH=16, BYTES_PER_WORD=4.
- One sub-module is natural: loader_word_assembler (byte shift register, 2-bit byte counter, running XOR checksum, word_ready flag).

Test Plan:
- Load three words 00500093, 00A00113, FFF00193: bytes 03 00 | 93 00 50 00 | 13 01 A0 00 | 93 01 F0 FF | EC -> three imem_we pulses at addr 0,1,2 with those data; done=1, core_hold=0, words_written=3. The core then yields x1=5, x2=10, x3=FFFFFFFF.
- Same stream with checksum byte 00 -> error=1, done=0, core_hold stays 1, 3 writes still observed.
- Length 0x0401 (>1024) -> ERROR right after LEN_HI; no imem_we; in_ready=0.
- Length 0 followed by checksum 00 -> DONE with no writes.
- Bursty in_valid (gaps of 0-3 cycles) plus start pulses mid-load -> identical writes to the first test; start ignored; in_ready=0 during each WRITE cycle.
- Assert rst after the 2nd word is written -> all outputs return to reset values asynchronously. A following start plus the full stream completes normally.
